cv32e40p_ft_alu_sched: RTL and testbench

- Fault-tolerance scheduler for the triplicated EX-stage ALU fed by the ID/EX pipeline register.
- Consumes per-replica mismatch reports from the EX voter and keeps saturating error scores with time decay.
- Retires a replica permanently once its score reaches threshold.
- Drives the EX output-select mux (sel_mux_ex) and the per-replica/voter clock enables (clock_enable_alu) for TMR → DMR → SIMPLEX → FAIL degradation.

---
 rtl/cv32e40p_ft_alu_sched.sv | 147 ++++++++++++++
 tb/tb_cv32e40p_ft_alu_sched.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_ft_alu_sched.sv
// TMR ALU fault scheduler: decaying per-replica error scores, sticky retirement, TMR->DMR->SIMPLEX->FAIL mux/clock control.
// State and outputs registered (one-cycle latency), no backpressure; FT_ALU_IDLE_GATE_EN adds idle clock gating with combinational wake.
module cv32e40p_ft_alu_sched #(
    parameter int ERR_CNT_WIDTH = 4,
    parameter int ERR_THRESHOLD = 8,
    parameter int DECAY_PERIOD  = 256,
    parameter int IDLE_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ex_valid_i,
    input  logic       alu_en_ex_i,
    input  logic       alu_en_id_i,
    input  logic [2:0] mismatch_i,
    input  logic       clear_i,
    output logic [2:0] sel_mux_ex_o,
    output logic [3:0] clock_enable_alu_o,
    output logic [2:0] faulty_o,
    output logic [1:0] mode_o,
    output logic       err_event_o
);

    localparam int CLW = $clog2(DECAY_PERIOD + 1);
    localparam logic [ERR_CNT_WIDTH-1:0] THR = ERR_CNT_WIDTH'(ERR_THRESHOLD);
    localparam logic [CLW-1:0] DECAY_LAST = CLW'(DECAY_PERIOD - 1);

    localparam logic [1:0] MODE_TMR     = 2'b00;
    localparam logic [1:0] MODE_DMR     = 2'b01;
    localparam logic [1:0] MODE_SIMPLEX = 2'b10;
    localparam logic [1:0] MODE_FAIL    = 2'b11;

    logic [2:0][ERR_CNT_WIDTH-1:0] score_q, score_d;
    logic [CLW-1:0] clean_q, clean_d;
    logic [2:0]     faulty_q, faulty_d, faulty_prev_q;
    logic [1:0]     mode_q, mode_d;
    logic [2:0]     sel_q, sel_d;
    logic           err_q;
    logic           sample;
    logic [2:0]     live_mis, reach, retire;
    logic [3:0]     cen_mode;

    assign sample   = ex_valid_i & alu_en_ex_i;
    assign live_mis = mismatch_i & ~faulty_q & {3{sample}};

    always_comb begin
        score_d = score_q;
        clean_d = clean_q;
        reach   = 3'b000;
        retire  = 3'b000;
        if (sample) begin
            if (|live_mis) begin
                clean_d = '0;
                for (int i = 0; i < 3; i++) begin
                    if (live_mis[i] && score_q[i] != THR) score_d[i] = score_q[i] + 1'b1;
                end
            end else if (clean_q == DECAY_LAST) begin
                clean_d = '0;
                for (int i = 0; i < 3; i++) begin
                    if (!faulty_q[i] && score_q[i] != '0) score_d[i] = score_q[i] - 1'b1;
                end
            end else begin
                clean_d = clean_q + 1'b1;
            end
        end
        for (int i = 0; i < 3; i++) begin
            reach[i] = live_mis[i] && (score_d[i] == THR);
        end
        // Only the highest index retires; simultaneous losers wait one short of threshold.
        if (reach[2])      retire = 3'b100;
        else if (reach[1]) retire = 3'b010;
        else if (reach[0]) retire = 3'b001;
        for (int i = 0; i < 3; i++) begin
            if (reach[i] && !retire[i]) score_d[i] = THR - 1'b1;
        end
        faulty_d = faulty_q | retire;
    end

    always_comb begin
        mode_d = {1'b0, faulty_d[0]} + {1'b0, faulty_d[1]} + {1'b0, faulty_d[2]};
        sel_d  = 3'b000;
        if (mode_d == MODE_DMR || mode_d == MODE_SIMPLEX) begin
            if (!faulty_d[0])      sel_d = 3'b001;
            else if (!faulty_d[1]) sel_d = 3'b010;
            else                   sel_d = 3'b100;
        end else if (mode_d == MODE_FAIL) begin
            sel_d = 3'b001;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q       <= '0;
            clean_q       <= '0;
            faulty_q      <= '0;
            faulty_prev_q <= '0;
            mode_q        <= MODE_TMR;
            sel_q         <= '0;
            err_q         <= 1'b0;
        end else if (clear_i) begin
            score_q       <= '0;
            clean_q       <= '0;
            faulty_q      <= '0;
            faulty_prev_q <= '0;
            mode_q        <= MODE_TMR;
            sel_q         <= '0;
            err_q         <= 1'b0;
        end else begin
            score_q       <= score_d;
            clean_q       <= clean_d;
            faulty_q      <= faulty_d;
            faulty_prev_q <= faulty_q;
            mode_q        <= mode_d;
            sel_q         <= sel_d;
            err_q         <= |(faulty_q & ~faulty_prev_q);
        end
    end

    assign cen_mode = {(mode_q == MODE_TMR) || (mode_q == MODE_DMR),
                       ~faulty_q[2], ~faulty_q[1], ~faulty_q[0] | (mode_q == MODE_FAIL)};

`ifdef FT_ALU_IDLE_GATE_EN
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    logic [IW-1:0] idle_q;
    logic          idle_now;

    assign idle_now = ~alu_en_ex_i & ~alu_en_id_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           idle_q <= '0;
        else if (clear_i || !idle_now)        idle_q <= '0;
        else if (idle_q != IW'(IDLE_CYCLES))  idle_q <= idle_q + 1'b1;
    end

    // Wake is combinational so replica clocks run before the instruction reaches EX.
    assign clock_enable_alu_o = (idle_q == IW'(IDLE_CYCLES) && idle_now) ? 4'b0000 : cen_mode;
`else
    logic unused_idle;
    assign unused_idle        = alu_en_id_i | (IDLE_CYCLES < 0);
    assign clock_enable_alu_o = cen_mode;
`endif

    assign faulty_o     = faulty_q;
    assign mode_o       = mode_q;
    assign sel_mux_ex_o = sel_q;
    assign err_event_o  = err_q;

endmodule

// File: tb/tb_cv32e40p_ft_alu_sched.sv
// Self-checking bench for cv32e40p_ft_alu_sched: directed scenarios plus random traffic against a score/queue-level model.
module tb_cv32e40p_ft_alu_sched;

    logic       clk = 1'b0;
    logic       rst_n, ex_valid, alu_en_ex, alu_en_id, clear;
    logic [2:0] mismatch;
    logic [2:0] sel_mux_ex, faulty;
    logic [3:0] clock_enable_alu;
    logic [1:0] mode;
    logic       err_event;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state
    int         m_score [3];
    int         m_clean;
    logic [2:0] m_faulty;
    logic       m_err, m_gained;
    int         m_idle;

    cv32e40p_ft_alu_sched dut (
        .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid), .alu_en_ex_i(alu_en_ex),
        .alu_en_id_i(alu_en_id), .mismatch_i(mismatch), .clear_i(clear),
        .sel_mux_ex_o(sel_mux_ex), .clock_enable_alu_o(clock_enable_alu),
        .faulty_o(faulty), .mode_o(mode), .err_event_o(err_event)
    );

    always #5 clk = ~clk;

    function automatic int n_dead(input logic [2:0] f);
        int c = 0;
        for (int i = 0; i < 3; i++) if (f[i]) c++;
        return c;
    endfunction

    function automatic logic [1:0] exp_mode(input logic [2:0] f);
        int c = n_dead(f);
        return c[1:0];
    endfunction

    function automatic logic [2:0] exp_sel(input logic [2:0] f);
        int c = n_dead(f);
        if (c == 0) return 3'b000;
        if (c == 3) return 3'b001;
        for (int i = 0; i < 3; i++) if (!f[i]) return 3'(1 << i);
        return 3'b000;
    endfunction

    function automatic logic [3:0] exp_cen(input logic [2:0] f);
        int c = n_dead(f);
`ifdef FT_ALU_IDLE_GATE_EN
        if (m_idle >= 4 && !alu_en_id && !alu_en_ex) return 4'b0000;
`endif
        return {c < 2, ~f[2], ~f[1], ~f[0] | (c == 3)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_score[i] = 0;
        m_clean = 0; m_faulty = 3'b000; m_err = 1'b0; m_gained = 1'b0; m_idle = 0;
    endtask

    task automatic model_edge();
        logic [2:0] live;
        int top;
        m_err    = m_gained;
        m_gained = 1'b0;
        if (clear || alu_en_ex || alu_en_id) m_idle = 0;
        else if (m_idle < 4) m_idle++;
        if (clear) begin
            for (int i = 0; i < 3; i++) m_score[i] = 0;
            m_clean = 0; m_faulty = 3'b000; m_err = 1'b0;
            return;
        end
        if (!(ex_valid && alu_en_ex)) return;
        live = mismatch & ~m_faulty;
        if (live != 3'b000) begin
            m_clean = 0;
            for (int i = 0; i < 3; i++) if (live[i] && m_score[i] < 8) m_score[i]++;
        end else begin
            m_clean++;
            if (m_clean == 256) begin
                m_clean = 0;
                for (int i = 0; i < 3; i++) if (!m_faulty[i] && m_score[i] > 0) m_score[i]--;
            end
        end
        top = -1;
        for (int i = 0; i < 3; i++) if (live[i] && m_score[i] == 8) top = i;
        if (top >= 0) begin
            for (int i = 0; i < 3; i++) if (live[i] && m_score[i] == 8 && i != top) m_score[i] = 7;
            m_faulty[top] = 1'b1;
            m_gained = 1'b1;
        end
    endtask

    task automatic step(input logic ev, input logic ae, input logic [2:0] mis, input logic clr, input logic id);
        ex_valid = ev; alu_en_ex = ae; mismatch = mis; clear = clr; alu_en_id = id;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; ex_valid = 0; alu_en_ex = 0; alu_en_id = 0; mismatch = 0; clear = 0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; ex_valid = 0; alu_en_ex = 1; alu_en_id = 1; mismatch = 0; clear = 0;
        #2;
        n_cmp++; if (faulty !== 3'b000) begin n_err++; $display("FAIL reset_faulty got=%b want=000", faulty); end
        n_cmp++; if (mode !== 2'b00) begin n_err++; $display("FAIL reset_mode got=%b want=00", mode); end
        n_cmp++; if (sel_mux_ex !== 3'b000) begin n_err++; $display("FAIL reset_sel got=%b want=000", sel_mux_ex); end
        n_cmp++; if (clock_enable_alu !== 4'b1111) begin n_err++; $display("FAIL reset_cen got=%b want=1111", clock_enable_alu); end
        n_cmp++; if (err_event !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b want=0", err_event); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single_retire();
        do_reset();
        for (int k = 0; k < 7; k++) step(1, 1, 3'b010, 0, 1);
        n_cmp++; if (faulty !== 3'b000) begin n_err++; $display("FAIL r1_after7 got=%b want=000", faulty); end
        step(1, 1, 3'b010, 0, 1);
        n_cmp++; if (faulty !== 3'b010) begin n_err++; $display("FAIL r1_faulty got=%b want=010", faulty); end
        n_cmp++; if (mode !== 2'b01) begin n_err++; $display("FAIL r1_mode got=%b want=01", mode); end
        n_cmp++; if (sel_mux_ex !== 3'b001) begin n_err++; $display("FAIL r1_sel got=%b want=001", sel_mux_ex); end
        n_cmp++; if (clock_enable_alu !== 4'b1101) begin n_err++; $display("FAIL r1_cen got=%b want=1101", clock_enable_alu); end
        n_cmp++; if (err_event !== 1'b0) begin n_err++; $display("FAIL r1_err_early got=%b want=0", err_event); end
        step(0, 1, 3'b000, 0, 1);
        n_cmp++; if (err_event !== 1'b1) begin n_err++; $display("FAIL r1_err_pulse got=%b want=1", err_event); end
        step(0, 1, 3'b000, 0, 1);
        n_cmp++; if (err_event !== 1'b0) begin n_err++; $display("FAIL r1_err_end got=%b want=0", err_event); end
    endtask

    task automatic test_decay();
        do_reset();
        for (int k = 0; k < 7; k++) step(1, 1, 3'b100, 0, 1);
        for (int k = 0; k < 255; k++) step(1, 1, 3'b000, 0, 1);
        step(1, 1, 3'b100, 0, 1);
        n_cmp++; if (faulty !== 3'b100) begin n_err++; $display("FAIL decay_255 got=%b want=100", faulty); end
        do_reset();
        for (int k = 0; k < 7; k++) step(1, 1, 3'b100, 0, 1);
        for (int k = 0; k < 256; k++) step(1, 1, 3'b000, 0, 1);
        step(1, 1, 3'b100, 0, 1);
        n_cmp++; if (faulty !== 3'b000) begin n_err++; $display("FAIL decay_256 got=%b want=000", faulty); end
        step(1, 1, 3'b100, 0, 1);
        n_cmp++; if (faulty !== 3'b100) begin n_err++; $display("FAIL decay_retire got=%b want=100", faulty); end
    endtask

    task automatic test_tie();
        do_reset();
        for (int k = 0; k < 7; k++) step(1, 1, 3'b011, 0, 1);
        step(1, 1, 3'b011, 0, 1);
        n_cmp++; if (faulty !== 3'b010) begin n_err++; $display("FAIL tie_faulty got=%b want=010", faulty); end
        step(1, 1, 3'b001, 0, 1);
        n_cmp++; if (faulty !== 3'b011) begin n_err++; $display("FAIL tie_held got=%b want=011", faulty); end
        n_cmp++; if (mode !== 2'b10) begin n_err++; $display("FAIL tie_mode got=%b want=10", mode); end
        n_cmp++; if (sel_mux_ex !== 3'b100) begin n_err++; $display("FAIL tie_sel got=%b want=100", sel_mux_ex); end
        n_cmp++; if (clock_enable_alu !== 4'b0100) begin n_err++; $display("FAIL tie_cen got=%b want=0100", clock_enable_alu); end
    endtask

    task automatic test_fail_clear();
        for (int k = 0; k < 8; k++) step(1, 1, 3'b100, 0, 1);
        n_cmp++; if (faulty !== 3'b111) begin n_err++; $display("FAIL fail_faulty got=%b want=111", faulty); end
        n_cmp++; if (mode !== 2'b11) begin n_err++; $display("FAIL fail_mode got=%b want=11", mode); end
        n_cmp++; if (sel_mux_ex !== 3'b001) begin n_err++; $display("FAIL fail_sel got=%b want=001", sel_mux_ex); end
        n_cmp++; if (clock_enable_alu !== 4'b0001) begin n_err++; $display("FAIL fail_cen got=%b want=0001", clock_enable_alu); end
        step(1, 1, 3'b111, 1, 1);
        n_cmp++; if ({faulty, mode, sel_mux_ex, clock_enable_alu, err_event} !== 13'b000_00_000_1111_0) begin
            n_err++; $display("FAIL clear_state got=%b_%b_%b_%b_%b want=000_00_000_1111_0",
                              faulty, mode, sel_mux_ex, clock_enable_alu, err_event);
        end
        for (int k = 0; k < 7; k++) step(1, 1, 3'b001, 0, 1);
        n_cmp++; if (faulty !== 3'b000) begin n_err++; $display("FAIL clear_scores got=%b want=000", faulty); end
        step(1, 1, 3'b001, 0, 1);
        n_cmp++; if (faulty !== 3'b001) begin n_err++; $display("FAIL clear_reretire got=%b want=001", faulty); end
    endtask

    task automatic test_unsampled();
        do_reset();
        for (int k = 0; k < 20; k++) step(1, 0, 3'b001, 0, 1);
        for (int k = 0; k < 20; k++) step(0, 1, 3'b001, 0, 1);
        for (int k = 0; k < 7; k++) step(1, 1, 3'b001, 0, 1);
        n_cmp++; if (faulty !== 3'b000) begin n_err++; $display("FAIL unsampled got=%b want=000", faulty); end
        step(1, 1, 3'b001, 0, 1);
        n_cmp++; if (faulty !== 3'b001) begin n_err++; $display("FAIL unsampled_8th got=%b want=001", faulty); end
    endtask

    task automatic test_mid_reset();
        step(0, 1, 3'b000, 0, 1);
        n_cmp++; if (err_event !== 1'b1) begin n_err++; $display("FAIL midrst_pre_err got=%b want=1", err_event); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({faulty, mode, sel_mux_ex, clock_enable_alu, err_event} !== 13'b000_00_000_1111_0) begin
            n_err++; $display("FAIL midrst_async got=%b_%b_%b_%b_%b want=000_00_000_1111_0",
                              faulty, mode, sel_mux_ex, clock_enable_alu, err_event);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 7; k++) step(1, 1, 3'b001, 0, 1);
        n_cmp++; if (faulty !== 3'b000) begin n_err++; $display("FAIL midrst_scores got=%b want=000", faulty); end
    endtask

    task automatic test_idle();
        logic [3:0] want;
        do_reset();
        for (int k = 0; k < 3; k++) step(0, 0, 3'b000, 0, 0);
        n_cmp++; if (clock_enable_alu !== 4'b1111) begin n_err++; $display("FAIL idle_3 got=%b want=1111", clock_enable_alu); end
        step(0, 0, 3'b000, 0, 0);
`ifdef FT_ALU_IDLE_GATE_EN
        want = 4'b0000;
`else
        want = 4'b1111;
`endif
        n_cmp++; if (clock_enable_alu !== want) begin n_err++; $display("FAIL idle_4 got=%b want=%b", clock_enable_alu, want); end
        alu_en_id = 1'b1;
        #1;
        n_cmp++; if (clock_enable_alu !== 4'b1111) begin n_err++; $display("FAIL idle_wake got=%b want=1111", clock_enable_alu); end
        step(0, 0, 3'b000, 0, 1);
    endtask

    task automatic test_random();
        logic [2:0] mis;
        for (int k = 0; k < 3000; k++) begin
            mis = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            step($urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, mis,
                 $urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);
            n_cmp++;
            if ({faulty, mode, sel_mux_ex, clock_enable_alu, err_event} !==
                {m_faulty, exp_mode(m_faulty), exp_sel(m_faulty), exp_cen(m_faulty), m_err}) begin
                n_err++;
                $display("FAIL rand_cycle%0d got=%b_%b_%b_%b_%b want=%b_%b_%b_%b_%b", k,
                         faulty, mode, sel_mux_ex, clock_enable_alu, err_event,
                         m_faulty, exp_mode(m_faulty), exp_sel(m_faulty), exp_cen(m_faulty), m_err);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1; ex_valid = 0; alu_en_ex = 0; alu_en_id = 0; mismatch = 0; clear = 0;
        model_reset();
        test_reset();
        test_single_retire();
        test_decay();
        test_tie();
        test_fail_clear();
        test_unsampled();
        test_mid_reset();
        test_idle();
        do_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
